uart_rx_mmio: RTL and testbench

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx.sv | 123 ++++++++++++
 rtl/uart_rx_mmio.sv | 123 ++++++++++++
 tb/tb_uart_rx_mmio.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register map, STATUS bits, FSM states.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Word index within the 16-byte window (bus_addr[3:2])
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RSVD0  = 2'd2;
    localparam logic [1:0] REG_RSVD1  = 2'd3;

    localparam int ST_OVERRUN    = 0;
    localparam int ST_FRAME_ERR  = 1;
    localparam int ST_EMPTY      = 2;
    localparam int ST_FULL       = 3;
    localparam int ST_PARITY_ERR = 4;

    localparam int CLR_OVERRUN    = 0;
    localparam int CLR_FRAME_ERR  = 1;
    localparam int CLR_PARITY_ERR = 2;

    function automatic logic [31:0] status_word(
        input logic [7:0] cnt,
        input logic       full,
        input logic       empty,
        input logic       ferr,
        input logic       ovr,
        input logic       perr
    );
        logic [31:0] w;
        w = '0;
        w[15:8]          = cnt;
        w[ST_PARITY_ERR] = perr;
        w[ST_FULL]       = full;
        w[ST_EMPTY]      = empty;
        w[ST_FRAME_ERR]  = ferr;
        w[ST_OVERRUN]    = ovr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Serial deserializer: 2-FF synchronizer, baud counter and frame FSM.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity check); default is 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_END = CW'(HALF - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic          rx_s;
    logic          fall;

    assign rx_s    = sync_q[1];
    assign fall    = prev_q & ~rx_s;
    assign rx_byte = shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_pin};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        rx_valid   = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == MID_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    // A line back high at mid-start is a glitch
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    perr_d  = ^{shift_q, rx_s};
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (!rx_s)       frame_err  = 1'b1;
                    else if (perr_q) parity_err = 1'b1;
                    else             rx_valid   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: RX FIFO plus RXDATA/STATUS register window.
// Define UART_RX_PARITY_EN to enable the even-parity check and STATUS parity_err.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ   = 50000000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_pin,
    input  logic                        bus_valid,
    input  logic                        bus_write,
    input  logic [31:0]                 bus_addr,
    input  logic [31:0]                 bus_wdata,
    output logic [31:0]                 mmio_rdata,
    output logic                        uart_ready,
    output logic                        rx_irq_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    logic          rx_perr;

    uart_rx #(
        .CLKS_PER_BIT(CLK_FREQ / BAUD_RATE)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_pin    (rx_pin),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (rx_ferr),
        .parity_err(rx_perr)
    );

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q;
    logic          overrun_q, frame_err_q, parity_err_q;
    logic          empty, full;
    logic          sel, is_rxdata, is_status;
    logic          pop, push, ovr_set, wr_st;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign sel       = bus_valid && (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign is_rxdata = (bus_addr[3:2] == REG_RXDATA);
    assign is_status = (bus_addr[3:2] == REG_STATUS);
    assign wr_st     = sel & bus_write & is_status;

    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign pop     = sel & ~bus_write & is_rxdata & ~empty;
    assign push    = rx_valid & (~full | pop);
    assign ovr_set = rx_valid & full & ~pop;

    assign uart_ready   = sel;
    assign rx_irq_o     = ~empty;
    assign fifo_count_o = count_q;

    always_comb begin
        mmio_rdata = '0;
        if (sel) begin
            unique case (1'b1)
                is_rxdata:
                    mmio_rdata = empty ? '0 : {23'b0, 1'b1, mem[rp_q]};
                is_status:
                    mmio_rdata = status_word(8'(count_q), full, empty,
                                             frame_err_q, overrun_q,
                                             parity_err_q);
                default: mmio_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            count_q     <= count_q + CW'(push) - CW'(pop);
            overrun_q   <= ovr_set |
                           (overrun_q & ~(wr_st & bus_wdata[CLR_OVERRUN]));
            frame_err_q <= rx_ferr |
                           (frame_err_q & ~(wr_st & bus_wdata[CLR_FRAME_ERR]));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= rx_byte;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else parity_err_q <= rx_perr |
                (parity_err_q & ~(wr_st & bus_wdata[CLR_PARITY_ERR]));
    end

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:3]};
`else
    assign parity_err_q = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:2], rx_perr};
`endif

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: scoreboard of expected RXDATA words.
module tb_uart_rx_mmio;

    localparam int          CLK_FREQ = 1_843_200;
    localparam int          BAUD     = 115200;
    localparam int          DEPTH    = 16;
    localparam int          CPB      = CLK_FREQ / BAUD;
    localparam logic [31:0] BASE     = 32'h1000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_pin = 1'b1;
    logic        bus_valid = 1'b0;
    logic        bus_write = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] mmio_rdata;
    logic        uart_ready;
    logic        rx_irq_o;
    logic [4:0]  fifo_count_o;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    uart_rx_mmio #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .FIFO_DEPTH(DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_pin      (rx_pin),
        .bus_valid   (bus_valid),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .mmio_rdata  (mmio_rdata),
        .uart_ready  (uart_ready),
        .rx_irq_o    (rx_irq_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rx_pin = fr[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Driver plus scoreboard update for frames that should land in the FIFO
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_byte(b, stop);
        if (stop && exp_q.size() < DEPTH) exp_q.push_back({1'b1, b});
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d,
                          output logic rdy);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_write = 1'b0;
        bus_addr  = addr;
        #1;
        d   = mmio_rdata;
        rdy = uart_ready;
        @(posedge clk);
        #1 bus_valid = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [31:0] d, exp;
        logic        r;
        exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h0;
        bus_rd(BASE, d, r);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: rxdata got %h want %h", name, d, exp);
        end
    endtask

    task automatic status_check(input string name, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        bus_rd(BASE + 32'h4, d, r);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: status got %h want %h", name, d, exp);
        end
    endtask

    task automatic count_check(input string name, input int exp);
        checks++;
        if (fifo_count_o !== 5'(exp)) begin
            errors++;
            $display("FAIL %s: count got %0d want %0d", name, fifo_count_o, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", rx_irq_o);
        end
        count_check("reset_count", 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        status_check("reset_status", 32'h0000_0004);
        pop_check("reset_rxdata");
        bus_rd(BASE + 32'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b0) begin
            errors++;
            $display("FAIL unselected: rdata %h ready %b want 0 0", d, r);
        end
        bus_wr(BASE + 32'h8, 32'hFFFF_FFFF);
        bus_rd(BASE + 32'hC, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_read: rdata %h ready %b want 0 1", d, r);
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1);
        status_check("single_status", 32'h0000_0100);
        checks++;
        if (rx_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL single_irq: got %b want 1", rx_irq_o);
        end
        pop_check("single_read");
        pop_check("single_empty_read");
        status_check("single_status_after", 32'h0000_0004);
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        count_check("ovr_count", 16);
        status_check("ovr_status", 32'h0000_1009);
        for (int i = 0; i < 16; i++) pop_check("ovr_drain");
        status_check("ovr_sticky", 32'h0000_0005);
        bus_wr(BASE + 32'h4, 32'h1);
        status_check("ovr_cleared", 32'h0000_0004);
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0);
        status_check("ferr_status", 32'h0000_0006);
        count_check("ferr_count", 0);
        bus_wr(BASE + 32'h4, 32'h2);
        status_check("ferr_cleared", 32'h0000_0004);
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1 rx_pin = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        status_check("glitch_status", 32'h0000_0004);
        send_frame(8'h5A, 1'b1);
        pop_check("glitch_rearm");
    endtask

    task automatic test_reset_midframe();
        logic [9:0] fr;
        send_frame(8'h11, 1'b1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 rx_pin = fr[i];
            repeat (CPB - 1) @(posedge clk);
        end
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        count_check("midrst_count", 0);
        checks++;
        if (rx_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_irq: got %b want 0", rx_irq_o);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rx_pin = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_frame(8'h81, 1'b1);
        pop_check("midrst_read");
        count_check("midrst_count_after", 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        r;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
        exp = 32'(exp_q.pop_front());
        exp_q.push_back({1'b1, 8'h30});
        fork
            send_byte(8'h30, 1'b1);
            begin
                @(posedge clk);
                repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
                bus_rd(BASE, d, r);
            end
        join
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL b2b_read: got %h want %h", d, exp);
        end
        count_check("b2b_count", 16);
        status_check("b2b_status", 32'h0000_1008);
        for (int i = 0; i < 16; i++) pop_check("b2b_drain");
        status_check("b2b_final", 32'h0000_0004);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
